// File: rtl/csr_ctrl_if.sv
// Request/response handshake between the EX stage and the CSR sequencer.
// The pipeline side is the master; csr_ctrl is the slave.
interface csr_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [11:0] req_addr;
   logic [31:0] req_src;
   logic        req_rs1_zero;
   logic [31:0] req_pc;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_illegal;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output req_valid, req_op, req_addr, req_src, req_rs1_zero, req_pc,
      input  req_ready, resp_valid, resp_rdata, resp_illegal,
      input  redirect_valid, redirect_pc
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_src, req_rs1_zero, req_pc,
      output req_ready, resp_valid, resp_rdata, resp_illegal,
      output redirect_valid, redirect_pc
   );
endinterface

// File: rtl/csr_ctrl.sv
// Machine-mode CSR sequencer: runs the read-modify-write of CSRRW/RS/RC,
// the ECALL trap entry and the MRET return against the CSR file's
// per-register write enables. Every output is a decode of registered state.
module csr_ctrl #(
   parameter logic [31:0] RESET_VAL = '0
) (
   input  logic        clock,
   input  logic        reset,
   csr_ctrl_if.slave   bus,
   input  logic        flush,
   input  logic [31:0] csr_mepc,
   input  logic [31:0] csr_mcause,
   input  logic [31:0] csr_mstatus,
   input  logic [31:0] csr_mtvec,
   input  logic [31:0] csr_mvendorid,
   input  logic [31:0] csr_marchid,
   output logic [3:0]  csr_wen,
   output logic [31:0] csrd,
   output logic        ecall_flag,
   output logic [31:0] trap_pc
);

   localparam logic [2:0] OP_RW    = 3'b001;
   localparam logic [2:0] OP_RS    = 3'b010;
   localparam logic [2:0] OP_RC    = 3'b011;
   localparam logic [2:0] OP_ECALL = 3'b100;
   localparam logic [2:0] OP_MRET  = 3'b101;

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
   localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WRITE,
      TRAP,
      TRAP_JUMP,
      RET
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [11:0] addr_q, addr_d;
   logic [31:0] src_q, src_d;
   logic        rs1_zero_q, rs1_zero_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] old_q, old_d;

   logic [31:0] read_val;
   logic [3:0]  wen_onehot;
   logic        addr_known;
   logic        addr_ro;
   logic        op_csr;
   logic        illegal;
   logic [31:0] new_val;

   // Decode the latched address and op: read mux, one-hot enable, legality and new value.
   always_comb begin
      read_val   = '0;
      wen_onehot = '0;
      addr_known = 1'b1;
      addr_ro    = 1'b0;
      case (addr_q)
         ADDR_MEPC:      begin read_val = csr_mepc;      wen_onehot = 4'b0001; end
         ADDR_MCAUSE:    begin read_val = csr_mcause;    wen_onehot = 4'b0010; end
         ADDR_MSTATUS:   begin read_val = csr_mstatus;   wen_onehot = 4'b0100; end
         ADDR_MTVEC:     begin read_val = csr_mtvec;     wen_onehot = 4'b1000; end
         ADDR_MVENDORID: begin read_val = csr_mvendorid; addr_ro = 1'b1; end
         ADDR_MARCHID:   begin read_val = csr_marchid;   addr_ro = 1'b1; end
         default:        addr_known = 1'b0;
      endcase
      op_csr  = (op_q == OP_RW) || (op_q == OP_RS) || (op_q == OP_RC);
      illegal = !op_csr || !addr_known ||
                (addr_ro && ((op_q == OP_RW) || !rs1_zero_q));
      case (op_q)
         OP_RW:   new_val = src_q;
         OP_RS:   new_val = old_q | src_q;
         OP_RC:   new_val = old_q & ~src_q;
         default: new_val = '0;
      endcase
   end

   // Next-state, request latching and output decode of the sequencer.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      src_d      = src_q;
      rs1_zero_d = rs1_zero_q;
      pc_d       = pc_q;
      old_d      = old_q;

      bus.req_ready      = 1'b0;
      bus.resp_valid     = 1'b0;
      bus.resp_rdata     = '0;
      bus.resp_illegal   = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      csr_wen            = '0;
      csrd               = '0;
      ecall_flag         = 1'b0;
      trap_pc            = '0;

      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               op_d       = bus.req_op;
               addr_d     = bus.req_addr;
               src_d      = bus.req_src;
               rs1_zero_d = bus.req_rs1_zero;
               pc_d       = bus.req_pc;
               case (bus.req_op)
                  OP_RW, OP_RS, OP_RC: state_d = READ;
                  OP_ECALL:            state_d = TRAP;
                  OP_MRET:             state_d = RET;
                  default:             state_d = WRITE;
               endcase
            end
         end
         READ: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               old_d   = read_val;
               state_d = WRITE;
            end
         end
         WRITE: begin
            csrd             = new_val;
            bus.resp_valid   = 1'b1;
            bus.resp_illegal = illegal;
            bus.resp_rdata   = illegal ? '0 : old_q;
            if (!illegal && !addr_ro && !((op_q != OP_RW) && rs1_zero_q)) begin
               csr_wen = wen_onehot;
            end
            state_d = IDLE;
         end
         TRAP: begin
            ecall_flag = 1'b1;
            trap_pc    = pc_q;
            state_d    = TRAP_JUMP;
         end
         TRAP_JUMP: begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = {csr_mtvec[31:2], 2'b00};
            bus.resp_valid     = 1'b1;
            state_d            = IDLE;
         end
         RET: begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = csr_mepc;
            bus.resp_valid     = 1'b1;
            state_d            = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and latched-request registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         op_q       <= RESET_VAL[2:0];
         addr_q     <= RESET_VAL[11:0];
         src_q      <= RESET_VAL;
         rs1_zero_q <= RESET_VAL[0];
         pc_q       <= RESET_VAL;
         old_q      <= RESET_VAL;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         src_q      <= src_d;
         rs1_zero_q <= rs1_zero_d;
         pc_q       <= pc_d;
         old_q      <= old_d;
      end
   end

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed testbench for csr_ctrl: CSR read-modify-write, read-only and
// illegal accesses, ECALL/MRET sequences, flush and mid-trap reset.
module tb_csr_ctrl;

   logic        clock;
   logic        reset;
   logic        flush;
   logic [31:0] csr_mepc, csr_mcause, csr_mstatus, csr_mtvec;
   logic [31:0] csr_mvendorid, csr_marchid;
   logic [3:0]  csr_wen;
   logic [31:0] csrd;
   logic        ecall_flag;
   logic [31:0] trap_pc;

   int check_count;
   int error_count;

   csr_ctrl_if bus ();

   csr_ctrl #(.RESET_VAL(32'h0)) dut (
      .clock         (clock),
      .reset         (reset),
      .bus           (bus),
      .flush         (flush),
      .csr_mepc      (csr_mepc),
      .csr_mcause    (csr_mcause),
      .csr_mstatus   (csr_mstatus),
      .csr_mtvec     (csr_mtvec),
      .csr_mvendorid (csr_mvendorid),
      .csr_marchid   (csr_marchid),
      .csr_wen       (csr_wen),
      .csrd          (csrd),
      .ecall_flag    (ecall_flag),
      .trap_pc       (trap_pc)
   );

   // Free-running 10-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   // Present one request at a negedge; returns just after the accepting edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [11:0] addr,
                                input logic [31:0] src, input logic rz,
                                input logic [31:0] pc);
      @(negedge clock);
      bus.req_valid    = 1'b1;
      bus.req_op       = op;
      bus.req_addr     = addr;
      bus.req_src      = src;
      bus.req_rs1_zero = rz;
      bus.req_pc       = pc;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
   endtask

   // A full CSR op: quiet READ cycle, write/response cycle, then ready again.
   task automatic runCsr(input string tag, input logic [2:0] op,
                         input logic [11:0] addr, input logic [31:0] src,
                         input logic rz, input logic [3:0] exp_wen,
                         input logic [31:0] exp_csrd, input logic [31:0] exp_rdata,
                         input logic exp_ill);
      applyStimulus(op, addr, src, rz, 32'h200);
      @(negedge clock);
      checkOutput({tag, "_n1_ready"}, 32'(bus.req_ready), 32'h0);
      checkOutput({tag, "_n1_wen"}, 32'(csr_wen), 32'h0);
      checkOutput({tag, "_n1_resp"}, 32'(bus.resp_valid), 32'h0);
      @(negedge clock);
      checkOutput({tag, "_wen"}, 32'(csr_wen), 32'(exp_wen));
      checkOutput({tag, "_csrd"}, csrd, exp_csrd);
      checkOutput({tag, "_resp"}, 32'(bus.resp_valid), 32'h1);
      checkOutput({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
      checkOutput({tag, "_ill"}, 32'(bus.resp_illegal), 32'(exp_ill));
      checkOutput({tag, "_ecall"}, 32'(ecall_flag), 32'h0);
      @(negedge clock);
      checkOutput({tag, "_n3_ready"}, 32'(bus.req_ready), 32'h1);
      checkOutput({tag, "_n3_wen"}, 32'(csr_wen), 32'h0);
   endtask

   // Main directed sequence.
   initial begin
      check_count      = 0;
      error_count      = 0;
      reset            = 1'b1;
      flush            = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_op       = '0;
      bus.req_addr     = '0;
      bus.req_src      = '0;
      bus.req_rs1_zero = 1'b0;
      bus.req_pc       = '0;
      csr_mepc         = 32'h0;
      csr_mcause       = 32'h0;
      csr_mstatus      = 32'h0;
      csr_mtvec        = 32'h0;
      csr_mvendorid    = 32'h79737978;
      csr_marchid      = 32'h00000023;

      repeat (2) @(negedge clock);
      checkOutput("rst_ready", 32'(bus.req_ready), 32'h1);
      checkOutput("rst_wen", 32'(csr_wen), 32'h0);
      checkOutput("rst_resp", 32'(bus.resp_valid), 32'h0);
      checkOutput("rst_redir", 32'(bus.redirect_valid), 32'h0);
      checkOutput("rst_ecall", 32'(ecall_flag), 32'h0);
      reset = 1'b0;

      runCsr("rw_mtvec", 3'b001, 12'h305, 32'h80000100, 1'b0,
             4'b1000, 32'h80000100, 32'h0, 1'b0);

      csr_mstatus = 32'h1800;
      runCsr("rs_mstatus", 3'b010, 12'h300, 32'h8, 1'b0,
             4'b0100, 32'h1808, 32'h1800, 1'b0);
      runCsr("rs_rz", 3'b010, 12'h300, 32'h8, 1'b1,
             4'b0000, 32'h1808, 32'h1800, 1'b0);

      csr_mstatus = 32'h1808;
      runCsr("rc_mstatus", 3'b011, 12'h300, 32'h8, 1'b0,
             4'b0100, 32'h1800, 32'h1808, 1'b0);
      runCsr("rs_vendor", 3'b010, 12'hF11, 32'h0, 1'b1,
             4'b0000, 32'h79737978, 32'h79737978, 1'b0);
      runCsr("rw_archid", 3'b001, 12'hF12, 32'h5, 1'b0,
             4'b0000, 32'h5, 32'h0, 1'b1);
      runCsr("rs_archid_nz", 3'b010, 12'hF12, 32'h1, 1'b0,
             4'b0000, 32'h23, 32'h0, 1'b1);

      csr_mepc   = 32'h44;
      csr_mcause = 32'h7;
      runCsr("rw_mepc", 3'b001, 12'h341, 32'h1234, 1'b0,
             4'b0001, 32'h1234, 32'h44, 1'b0);
      runCsr("rc_mcause", 3'b011, 12'h342, 32'h3, 1'b0,
             4'b0010, 32'h4, 32'h7, 1'b0);
      runCsr("rw_badaddr", 3'b001, 12'h123, 32'h9, 1'b0,
             4'b0000, 32'h9, 32'h0, 1'b1);

      // Illegal op skips READ and responds one cycle after acceptance.
      applyStimulus(3'b111, 12'h300, 32'hF, 1'b0, 32'h300);
      @(negedge clock);
      checkOutput("badop_resp", 32'(bus.resp_valid), 32'h1);
      checkOutput("badop_ill", 32'(bus.resp_illegal), 32'h1);
      checkOutput("badop_wen", 32'(csr_wen), 32'h0);
      checkOutput("badop_rdata", bus.resp_rdata, 32'h0);
      @(negedge clock);
      checkOutput("badop_ready", 32'(bus.req_ready), 32'h1);

      // ECALL followed by MRET.
      csr_mtvec = 32'h80000101;
      applyStimulus(3'b100, 12'h0, 32'h0, 1'b0, 32'h1000);
      @(negedge clock);
      checkOutput("ecall_flag", 32'(ecall_flag), 32'h1);
      checkOutput("ecall_trappc", trap_pc, 32'h1000);
      checkOutput("ecall_wen", 32'(csr_wen), 32'h0);
      checkOutput("ecall_n1_redir", 32'(bus.redirect_valid), 32'h0);
      @(negedge clock);
      checkOutput("ecall_redir", 32'(bus.redirect_valid), 32'h1);
      checkOutput("ecall_redirpc", bus.redirect_pc, 32'h80000100);
      checkOutput("ecall_resp", 32'(bus.resp_valid), 32'h1);
      checkOutput("ecall_n2_flag", 32'(ecall_flag), 32'h0);
      @(negedge clock);
      checkOutput("ecall_ready", 32'(bus.req_ready), 32'h1);

      csr_mepc = 32'h1000;
      applyStimulus(3'b101, 12'h0, 32'h0, 1'b0, 32'h2000);
      @(negedge clock);
      checkOutput("mret_redir", 32'(bus.redirect_valid), 32'h1);
      checkOutput("mret_redirpc", bus.redirect_pc, 32'h1000);
      checkOutput("mret_resp", 32'(bus.resp_valid), 32'h1);
      checkOutput("mret_rdata", bus.resp_rdata, 32'h0);
      @(negedge clock);
      checkOutput("mret_ready", 32'(bus.req_ready), 32'h1);
      checkOutput("mret_n2_redir", 32'(bus.redirect_valid), 32'h0);

      // Flush while the CSRRW sits in READ.
      applyStimulus(3'b001, 12'h305, 32'hABCD, 1'b0, 32'h400);
      flush = 1'b1;
      @(negedge clock);
      checkOutput("flush_read_resp", 32'(bus.resp_valid), 32'h0);
      @(posedge clock);
      #1;
      flush = 1'b0;
      @(negedge clock);
      checkOutput("flush_ready", 32'(bus.req_ready), 32'h1);
      checkOutput("flush_wen", 32'(csr_wen), 32'h0);
      checkOutput("flush_resp", 32'(bus.resp_valid), 32'h0);
      @(negedge clock);
      checkOutput("flush_n3_wen", 32'(csr_wen), 32'h0);

      // Reset while in TRAP drops the redirect.
      applyStimulus(3'b100, 12'h0, 32'h0, 1'b0, 32'h3000);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("trst_redir", 32'(bus.redirect_valid), 32'h0);
      checkOutput("trst_resp", 32'(bus.resp_valid), 32'h0);
      checkOutput("trst_ecall", 32'(ecall_flag), 32'h0);
      checkOutput("trst_wen", 32'(csr_wen), 32'h0);
      checkOutput("trst_ready", 32'(bus.req_ready), 32'h1);
      checkOutput("trst_trappc", trap_pc, 32'h0);
      checkOutput("trst_redirpc", bus.redirect_pc, 32'h0);
      checkOutput("trst_csrd", csrd, 32'h0);
      checkOutput("trst_rdata", bus.resp_rdata, 32'h0);
      checkOutput("trst_ill", 32'(bus.resp_illegal), 32'h0);
      @(negedge clock);
      checkOutput("trst_n2_redir", 32'(bus.redirect_valid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
